// File: rtl/regfile_mp_pkg.sv
// Shared register-file types and sizes for the core.
package regfile_mp_pkg;

  localparam int unsigned RegfileRegs = 32;
  localparam int unsigned RegAddrW    = $clog2(RegfileRegs);

  typedef logic [RegfileRegs-1:0] rf_busy_t;
  typedef logic [RegAddrW-1:0]    reg_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker with a registered population count.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NumRegs  = RegfileRegs,
  parameter int unsigned NumWrite = 1,
  parameter int unsigned AddrW    = $clog2(NumRegs)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alloc_valid,
  input  logic [AddrW-1:0]          alloc_rd,
  input  logic [NumWrite-1:0]       wb_valid,
  input  logic [NumWrite*AddrW-1:0] wb_rd,
  output logic [NumRegs-1:0]        busy,
  output logic [AddrW:0]            busy_count
);

  localparam int unsigned CountW = AddrW + 1;

  logic [NumRegs-1:0] busy_nxt;
  logic [CountW-1:0]  count_nxt;

  // Next busy vector: write-backs clear, alloc sets afterwards so a new producer wins.
  always_comb begin
    busy_nxt  = busy;
    count_nxt = '0;
    for (int j = 0; j < int'(NumWrite); j++) begin
      if (wb_valid[j]) begin
        busy_nxt[wb_rd[j*AddrW +: AddrW]] = 1'b0;
      end
    end
    if (alloc_valid) begin
      busy_nxt[alloc_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    for (int r = 1; r < int'(NumRegs); r++) begin
      count_nxt = count_nxt + CountW'(busy_nxt[r]);
    end
  end

  // Busy bits and their count update together so the count never lags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-back bypass and RAW scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned NumRegs  = RegfileRegs,
  parameter int unsigned NumRead  = 2,
  parameter int unsigned NumWrite = 1,
  parameter int unsigned Bypass   = 1,
  parameter int unsigned AddrW    = $clog2(NumRegs)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NumRead*AddrW-1:0]  rs_addr,
  input  logic [NumRead-1:0]        rs_valid,
  output logic [NumRead*Width-1:0]  rs_data,
  output logic [NumRead-1:0]        rs_busy,
  input  logic                      alloc_valid,
  input  logic [AddrW-1:0]          alloc_rd,
  input  logic [NumWrite-1:0]       wb_valid,
  input  logic [NumWrite*AddrW-1:0] wb_rd,
  input  logic [NumWrite*Width-1:0] wb_data,
  output logic [AddrW:0]            busy_count
);

  // Entry 0 is reset and never written, so it folds away to a constant zero.
  logic [Width-1:0]   regs [NumRegs];
  logic [NumRegs-1:0] busy;
  logic [AddrW-1:0]   rd_addr;

  regfile_scoreboard #(
    .NumRegs  (NumRegs),
    .NumWrite (NumWrite),
    .AddrW    (AddrW)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .alloc_valid (alloc_valid && (alloc_rd != '0)),
    .alloc_rd    (alloc_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .busy        (busy),
    .busy_count  (busy_count)
  );

  // Write-back: ports applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(NumRegs); r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < int'(NumWrite); j++) begin
        if (wb_valid[j] && (wb_rd[j*AddrW +: AddrW] != '0)) begin
          regs[wb_rd[j*AddrW +: AddrW]] <= wb_data[j*Width +: Width];
        end
      end
    end
  end

  // Read ports: stored value and busy bit, overridden by a matching same-cycle write-back.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    rd_addr = '0;
    for (int i = 0; i < int'(NumRead); i++) begin
      rd_addr = rs_addr[i*AddrW +: AddrW];
      if (rs_valid[i] && (rd_addr != '0)) begin
        rs_data[i*Width +: Width] = regs[rd_addr];
        rs_busy[i]                = busy[rd_addr];
        if (Bypass != 0) begin
          for (int j = 0; j < int'(NumWrite); j++) begin
            if (wb_valid[j] && (wb_rd[j*AddrW +: AddrW] == rd_addr)) begin
              rs_data[i*Width +: Width] = wb_data[j*Width +: Width];
              rs_busy[i]                = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two DUTs (bypass on/off) share stimulus and a reference model.
module tb_regfile_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned NG = 32;
  localparam int unsigned AW = 5;

  typedef struct packed {
    logic [NR-1:0]         rs_valid;
    logic [NR-1:0][AW-1:0] rs_addr;
    logic                  alloc_valid;
    logic [AW-1:0]         alloc_rd;
    logic [NW-1:0]         wb_valid;
    logic [NW-1:0][AW-1:0] wb_rd;
    logic [NW-1:0][W-1:0]  wb_data;
  } stim_t;

  typedef struct {
    logic [W-1:0] data    [NR];
    logic         busy    [NR];
    logic [W-1:0] data_nb [NR];
    logic         busy_nb [NR];
    int           cnt;
    string        tag;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic [NR*AW-1:0]  rs_addr;
  logic [NR-1:0]     rs_valid;
  logic [NR*W-1:0]   rs_data, rs_data_nb;
  logic [NR-1:0]     rs_busy, rs_busy_nb;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_rd;
  logic [NW-1:0]     wb_valid;
  logic [NW*AW-1:0]  wb_rd;
  logic [NW*W-1:0]   wb_data;
  logic [AW:0]       busy_count, busy_count_nb;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_mem  [NG];
  bit           m_busy [NG];
  stim_t        cur;
  exp_t         exp_q [$];

  regfile_mp #(.Width(W), .NumRegs(NG), .NumRead(NR), .NumWrite(NW), .Bypass(1)) dut (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_valid(rs_valid),
    .rs_data(rs_data), .rs_busy(rs_busy), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_count(busy_count)
  );

  regfile_mp #(.Width(W), .NumRegs(NG), .NumRead(NR), .NumWrite(NW), .Bypass(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_valid(rs_valid),
    .rs_data(rs_data_nb), .rs_busy(rs_busy_nb), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_count(busy_count_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < int'(NG); r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  // Architectural effect of one clock edge.
  function automatic void model_update(input stim_t s);
    for (int j = 0; j < int'(NW); j++) begin
      if (s.wb_valid[j] && s.wb_rd[j] != 0) begin
        m_mem[s.wb_rd[j]]  = s.wb_data[j];
        m_busy[s.wb_rd[j]] = 1'b0;
      end
    end
    if (s.alloc_valid && s.alloc_rd != 0) m_busy[s.alloc_rd] = 1'b1;
  endfunction

  function automatic exp_t predict(input stim_t s, input string tag);
    exp_t e;
    int   hit;
    e.tag = tag;
    e.cnt = 0;
    for (int r = 1; r < int'(NG); r++) e.cnt += int'(m_busy[r]);
    for (int i = 0; i < int'(NR); i++) begin
      e.data[i] = '0; e.busy[i] = 1'b0; e.data_nb[i] = '0; e.busy_nb[i] = 1'b0;
      if (s.rs_valid[i] && s.rs_addr[i] != 0) begin
        e.data_nb[i] = m_mem[s.rs_addr[i]];
        e.busy_nb[i] = m_busy[s.rs_addr[i]];
        hit = -1;
        for (int j = 0; j < int'(NW); j++)
          if (s.wb_valid[j] && s.wb_rd[j] == s.rs_addr[i]) hit = j;
        if (hit >= 0) begin
          e.data[i] = s.wb_data[hit];
          e.busy[i] = 1'b0;
        end else begin
          e.data[i] = e.data_nb[i];
          e.busy[i] = e.busy_nb[i];
        end
      end
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic check(input exp_t e);
    for (int i = 0; i < int'(NR); i++) begin
      cmp($sformatf("%s data[%0d]", e.tag, i), rs_data[i*W +: W], e.data[i]);
      cmp($sformatf("%s busy[%0d]", e.tag, i), W'(rs_busy[i]), W'(e.busy[i]));
      cmp($sformatf("%s nb_data[%0d]", e.tag, i), rs_data_nb[i*W +: W], e.data_nb[i]);
      cmp($sformatf("%s nb_busy[%0d]", e.tag, i), W'(rs_busy_nb[i]), W'(e.busy_nb[i]));
    end
    cmp({e.tag, " busy_count"}, W'(busy_count), W'(e.cnt));
    cmp({e.tag, " nb_busy_count"}, W'(busy_count_nb), W'(e.cnt));
  endtask

  task automatic drive(input stim_t s);
    rs_valid    = s.rs_valid;
    rs_addr     = s.rs_addr;
    alloc_valid = s.alloc_valid;
    alloc_rd    = s.alloc_rd;
    wb_valid    = s.wb_valid;
    wb_rd       = s.wb_rd;
    wb_data     = s.wb_data;
  endtask

  // Apply one cycle of stimulus just after the edge and queue its expected response.
  task automatic step(input stim_t s, input string tag);
    @(posedge clk);
    #1;
    model_update(cur);
    cur = s;
    drive(s);
    exp_q.push_back(predict(s, tag));
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    for (int i = 0; i < int'(NR); i++) begin
      s.rs_valid[i] = ($urandom_range(0, 3) != 0);
      s.rs_addr[i]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
    end
    s.alloc_valid = ($urandom_range(0, 2) == 0);
    s.alloc_rd    = AW'($urandom_range(0, 7));
    for (int j = 0; j < int'(NW); j++) begin
      s.wb_valid[j] = ($urandom_range(0, 2) == 0);
      s.wb_rd[j]    = AW'($urandom_range(0, 7));
      s.wb_data[j]  = $urandom;
    end
    return s;
  endfunction

  // Monitor: compare the oldest expectation in the quiet half of each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e;
    cur = '0;
    drive(cur);
    model_reset();
    reset_n = 1'b0;
    #2;
    check(predict(cur, "por"));
    #1 reset_n = 1'b1;

    // Reset mid-operation after populating x5 and reserving x6.
    s = '0; s.wb_valid[0] = 1'b1; s.wb_rd[0] = 5'd5; s.wb_data[0] = 32'hDEADBEEF;
    s.alloc_valid = 1'b1; s.alloc_rd = 5'd6;
    step(s, "wr_x5");
    s = '0; s.rs_valid = 4'b0011; s.rs_addr[0] = 5'd5; s.rs_addr[1] = 5'd6;
    step(s, "rd_x5");
    #5;
    reset_n = 1'b0;
    #1;
    model_reset();
    check(predict(cur, "mid_reset"));
    #1 reset_n = 1'b1;

    // x0 is never written and never busy.
    s = '0; s.wb_valid[0] = 1'b1; s.wb_rd[0] = 5'd0; s.wb_data[0] = 32'h1234;
    s.alloc_valid = 1'b1; s.alloc_rd = 5'd0; s.rs_valid[0] = 1'b1;
    step(s, "x0_wr");
    s = '0; s.rs_valid[0] = 1'b1;
    step(s, "x0_rd");

    // Bypass vs. no bypass on x7.
    s = '0; s.wb_valid[0] = 1'b1; s.wb_rd[0] = 5'd7; s.wb_data[0] = 32'h11111111;
    step(s, "x7_init");
    s = '0; s.wb_valid[0] = 1'b1; s.wb_rd[0] = 5'd7; s.wb_data[0] = 32'hA5A5A5A5;
    s.rs_valid = 4'b0011; s.rs_addr[0] = 5'd7; s.rs_addr[1] = 5'd7;
    step(s, "x7_bypass");
    s = '0; s.rs_valid = 4'b0011; s.rs_addr[0] = 5'd7; s.rs_addr[1] = 5'd7;
    step(s, "x7_next");

    // Scoreboard set / clear on x3.
    s = '0; s.alloc_valid = 1'b1; s.alloc_rd = 5'd3;
    step(s, "x3_alloc");
    s = '0; s.rs_valid[0] = 1'b1; s.rs_addr[0] = 5'd3;
    step(s, "x3_busy");
    s = '0; s.wb_valid[0] = 1'b1; s.wb_rd[0] = 5'd3; s.wb_data[0] = 32'h10;
    step(s, "x3_wb");
    s = '0; s.rs_valid[0] = 1'b1; s.rs_addr[0] = 5'd3;
    step(s, "x3_done");

    // Alloc and write-back to x9 in the same cycle: stays busy.
    s = '0; s.alloc_valid = 1'b1; s.alloc_rd = 5'd9;
    s.wb_valid[1] = 1'b1; s.wb_rd[1] = 5'd9; s.wb_data[1] = 32'h55;
    step(s, "x9_both");
    s = '0; s.rs_valid[0] = 1'b1; s.rs_addr[0] = 5'd9;
    step(s, "x9_rd");

    // Both write ports on x4; highest port wins.
    s = '0; s.wb_valid = 2'b11; s.wb_rd[0] = 5'd4; s.wb_rd[1] = 5'd4;
    s.wb_data[0] = 32'h11; s.wb_data[1] = 32'h22;
    s.rs_valid[2] = 1'b1; s.rs_addr[2] = 5'd4;
    step(s, "x4_collide");
    s = '0; s.rs_valid = 4'b1111;
    s.rs_addr[0] = 5'd3; s.rs_addr[1] = 5'd4; s.rs_addr[2] = 5'd7; s.rs_addr[3] = 5'd9;
    step(s, "four_ports");

    for (int n = 0; n < 400; n++) step(rand_stim(), $sformatf("rand%0d", n));

    s = '0;
    step(s, "idle");
    repeat (3) @(negedge clk);
    #1;
    cmp("queue_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
